// File: rtl/agua_pkg.sv
// Shared definitions for the water-level measurement sequencer.
package agua_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    MEDE    = 4'd2,
    AGUARDA = 4'd3,
    CONTA   = 4'd4,
    ESPERA  = 4'd5,
    DECIDE  = 4'd6,
    FINAL   = 4'd7,
    ERRO    = 4'd8
  } estado_t;

  localparam logic [1:0] MODO_PEQUENO = 2'b01;
  localparam logic [1:0] MODO_GRANDE  = 2'b10;

  function automatic logic modo_valido(input logic [1:0] m);
    return (m == MODO_PEQUENO) || (m == MODO_GRANDE);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Interval timer: loaded by zera_s, counts down while conta is high.
// fim is high on the M-th counted cycle after a load.
module contador_m #(
  parameter int M = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_s,
  input  logic conta,
  output logic fim
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] CARGA = W'(M - 1);

  logic [W-1:0] restante;

  // Down-counter with terminal-count compare; holds at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      restante <= '0;
    end else if (zera_s) begin
      restante <= CARGA;
    end else if (conta && (restante != '0)) begin
      restante <= restante - W'(1);
    end
  end

  assign fim = (restante == '0);

endmodule

// File: rtl/verifica_agua.sv
// Water-level measurement sequencer: triggers the sensor, collects
// N_AMOSTRAS valid readings with bounded retries, then issues a majority
// verdict or a sensor error.
//
// state   | meaning
// INICIAL | idle, waiting for iniciar
// PREPARA | zera_sensor pulse, clears sensor timeout counter
// MEDE    | medir pulse
// AGUARDA | waiting for pronto_sensor or timeout_sensor
// CONTA   | reading counted, decide whether more are needed
// ESPERA  | idle interval between readings
// DECIDE  | majority vote
// FINAL   | pronto pulse with verdict
// ERRO    | pronto pulse with erro
import agua_pkg::*;

module verifica_agua #(
  parameter int N_AMOSTRAS     = 3,
  parameter int MAX_TENTATIVAS = 2,
  parameter int INTERVALO      = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] modo,
  input  logic       pronto_sensor,
  input  logic       suficiente,
  input  logic       timeout_sensor,
  output logic       medir,
  output logic       zera_sensor,
  output logic [1:0] modo_sensor,
  output logic       pronto,
  output logic       agua_ok,
  output logic       erro,
  output logic [3:0] db_estado
);

  localparam int WA = $clog2(N_AMOSTRAS + 1);
  localparam int WT = $clog2(MAX_TENTATIVAS + 2);
  localparam int WM = WA + 1;
  localparam logic [WA-1:0] N_A     = WA'(N_AMOSTRAS);
  localparam logic [WT-1:0] MAX_T   = WT'(MAX_TENTATIVAS);
  localparam logic [WM-1:0] N_MAIOR = WM'(N_AMOSTRAS);

  estado_t       estado;
  logic [WA-1:0] amostras;
  logic [WA-1:0] acertos;
  logic [WT-1:0] tentativas;
  logic [WT-1:0] tentativas_inc;
  logic          fim_intervalo;

  assign tentativas_inc = tentativas + WT'(1);

  contador_m #(.M(INTERVALO)) u_intervalo (
    .clock  (clock),
    .reset  (reset),
    .zera_s (estado == CONTA),
    .conta  (estado == ESPERA),
    .fim    (fim_intervalo)
  );

  // Sequencer FSM; pulse outputs are registered on entry to their state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= INICIAL;
      amostras    <= '0;
      acertos     <= '0;
      tentativas  <= '0;
      medir       <= 1'b0;
      zera_sensor <= 1'b0;
      modo_sensor <= '0;
      pronto      <= 1'b0;
      agua_ok     <= 1'b0;
      erro        <= 1'b0;
    end else begin
      medir       <= 1'b0;
      zera_sensor <= 1'b0;
      pronto      <= 1'b0;
      case (estado)
        INICIAL: begin
          if (iniciar) begin
            if (modo_valido(modo)) begin
              estado      <= PREPARA;
              zera_sensor <= 1'b1;
              modo_sensor <= modo;
              agua_ok     <= 1'b0;
              erro        <= 1'b0;
              amostras    <= '0;
              acertos     <= '0;
              tentativas  <= '0;
            end else begin
              estado  <= ERRO;
              pronto  <= 1'b1;
              erro    <= 1'b1;
              agua_ok <= 1'b0;
            end
          end
        end
        PREPARA: begin
          estado <= MEDE;
          medir  <= 1'b1;
        end
        MEDE: estado <= AGUARDA;
        AGUARDA: begin
          // a completed reading takes priority over a simultaneous timeout
          if (pronto_sensor) begin
            amostras   <= amostras + WA'(1);
            acertos    <= acertos + WA'(suficiente);
            tentativas <= '0;
            estado     <= CONTA;
          end else if (timeout_sensor) begin
            tentativas <= tentativas_inc;
            if (tentativas_inc <= MAX_T) begin
              estado      <= PREPARA;
              zera_sensor <= 1'b1;
            end else begin
              estado  <= ERRO;
              pronto  <= 1'b1;
              erro    <= 1'b1;
              agua_ok <= 1'b0;
            end
          end
        end
        CONTA: begin
          if (amostras == N_A) estado <= DECIDE;
          else                 estado <= ESPERA;
        end
        ESPERA: begin
          if (fim_intervalo) begin
            estado      <= PREPARA;
            zera_sensor <= 1'b1;
          end
        end
        DECIDE: begin
          agua_ok <= ({acertos, 1'b0} > N_MAIOR);
          pronto  <= 1'b1;
          estado  <= FINAL;
        end
        FINAL:   estado <= INICIAL;
        ERRO:    estado <= INICIAL;
        default: estado <= INICIAL;
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_verifica_agua.sv
// Bench for verifica_agua: a transaction-level schedule of expected
// pulses and held values, checked against the DUT on every cycle.
`timescale 1ns/1ps
module tb_verifica_agua;

  localparam int N    = 3;
  localparam int MAXT = 2;
  localparam int IV   = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       pronto_sensor = 1'b0;
  logic       suficiente = 1'b0;
  logic       timeout_sensor = 1'b0;
  logic       medir, zera_sensor, pronto, agua_ok, erro;
  logic [1:0] modo_sensor;
  logic [3:0] db_estado;

  verifica_agua #(.N_AMOSTRAS(N), .MAX_TENTATIVAS(MAXT), .INTERVALO(IV)) dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .modo           (modo),
    .pronto_sensor  (pronto_sensor),
    .suficiente     (suficiente),
    .timeout_sensor (timeout_sensor),
    .medir          (medir),
    .zera_sensor    (zera_sensor),
    .modo_sensor    (modo_sensor),
    .pronto         (pronto),
    .agua_ok        (agua_ok),
    .erro           (erro),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // cycle c is the period ending at rising edge number c
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // expected schedule, keyed by cycle
  bit         exp_medir[int];
  bit         exp_zera[int];
  bit         exp_pronto[int];
  logic [3:0] exp_db[int];
  bit         upd_ok[int];
  bit         upd_err[int];
  bit         upd_idle[int];
  logic [1:0] upd_ms[int];
  bit         exp_ok = 1'b0, exp_err = 1'b0, exp_idle = 1'b1;
  logic [1:0] exp_ms = 2'b00;

  int n_medir, last_medir, min_gap, last_pronto, seq_start, last_k;
  int script[$];

  task automatic chk(input string nome, input logic [3:0] got, input logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nome, cyc, got, want);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (upd_ok.exists(cyc))   exp_ok   = upd_ok[cyc];
      if (upd_err.exists(cyc))  exp_err  = upd_err[cyc];
      if (upd_idle.exists(cyc)) exp_idle = upd_idle[cyc];
      if (upd_ms.exists(cyc))   exp_ms   = upd_ms[cyc];
      chk("medir",       {3'b000, medir},       exp_medir.exists(cyc)  ? 4'd1 : 4'd0);
      chk("zera_sensor", {3'b000, zera_sensor}, exp_zera.exists(cyc)   ? 4'd1 : 4'd0);
      chk("pronto",      {3'b000, pronto},      exp_pronto.exists(cyc) ? 4'd1 : 4'd0);
      chk("agua_ok",     {3'b000, agua_ok},     {3'b000, exp_ok});
      chk("erro",        {3'b000, erro},        {3'b000, exp_err});
      chk("modo_sensor", {2'b00, modo_sensor},  {2'b00, exp_ms});
      if (exp_db.exists(cyc)) chk("db_estado", db_estado, exp_db[cyc]);
      else if (exp_idle)      chk("db_estado_idle", db_estado, 4'd0);
      if (medir === 1'b1) begin
        if (last_medir >= 0 && (cyc - last_medir) < min_gap) min_gap = cyc - last_medir;
        last_medir = cyc;
        n_medir++;
      end
      if (pronto === 1'b1) last_pronto = cyc;
    end
  end

  always @(posedge clock) begin
    if (cyc > 30000) begin
      $display("FAIL watchdog: cycle budget exceeded at cycle %0d", cyc);
      $fatal(1, "watchdog");
    end
  end

  task automatic drive_idle(input bit noisy);
    reset = 1'b0;
    if (noisy) begin
      iniciar        = ($urandom_range(0, 3) == 0);
      pronto_sensor  = ($urandom_range(0, 3) == 0);
      timeout_sensor = ($urandom_range(0, 3) == 0);
      suficiente     = 1'($urandom_range(0, 1));
      modo           = 2'($urandom_range(0, 3));
    end else begin
      iniciar        = 1'b0;
      pronto_sensor  = 1'b0;
      timeout_sensor = 1'b0;
      suficiente     = 1'b0;
    end
  endtask

  // advance to the drive slot of cycle c; earlier cycles get idle/noise
  task automatic at_cycle(input int c, input bit noisy);
    while (cyc < c) begin
      @(negedge clock);
      drive_idle(noisy && (cyc < c));
    end
  endtask

  function automatic int random_code();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return 0;
    if (r < 8) return 1;
    if (r == 8) return 2;
    return 3 + $urandom_range(0, 1);
  endfunction

  // codes: 0/1 reading with suficiente=0/1, 2 timeout,
  // 3/4 reading and timeout together with suficiente=1/0
  task automatic run_seq(input logic [1:0] m, input bit do_reset);
    int c0, t, k, r, p, amostras, acertos, tent, code;
    bit fim, leu, suf;
    c0 = cyc + 1 + $urandom_range(0, 2);
    at_cycle(c0, 1'b0);
    iniciar = 1'b1;
    modo = m;
    n_medir = 0; min_gap = 1000; last_medir = -1000; last_pronto = -1;
    seq_start = c0;
    p = c0 + 1;
    if (!(m == 2'b01 || m == 2'b10)) begin
      exp_pronto[c0+1] = 1'b1; exp_db[c0+1] = 4'd8;
      upd_err[c0+1] = 1'b1; upd_ok[c0+1] = 1'b0;
      upd_idle[c0+1] = 1'b0; upd_idle[c0+2] = 1'b1;
    end else begin
      upd_ok[c0+1] = 1'b0; upd_err[c0+1] = 1'b0; upd_ms[c0+1] = m; upd_idle[c0+1] = 1'b0;
      exp_zera[c0+1] = 1'b1; exp_db[c0+1] = 4'd1;
      exp_medir[c0+2] = 1'b1; exp_db[c0+2] = 4'd2;
      t = c0 + 2; amostras = 0; acertos = 0; tent = 0; fim = 1'b0;
      while (!fim) begin
        k = t + $urandom_range(1, 4);
        at_cycle(t, 1'b1);
        at_cycle(k, 1'b0);
        last_k = k;
        code = (script.size() > 0) ? script.pop_front() : random_code();
        leu = (code != 2);
        suf = (code == 1) || (code == 3);
        pronto_sensor  = leu;
        timeout_sensor = (code >= 2);
        suficiente     = (code == 2) ? 1'($urandom_range(0, 1)) : suf;
        if (leu) begin
          amostras++; acertos += int'(suf); tent = 0;
          if (amostras == N) begin
            p = k + 3;
            exp_pronto[p] = 1'b1; exp_db[p] = 4'd7;
            upd_ok[p] = (2 * acertos > N); upd_idle[p+1] = 1'b1;
            fim = 1'b1;
          end else if (do_reset) begin
            r = k + 2 + $urandom_range(0, IV - 1);
            at_cycle(r, 1'b1);
            reset = 1'b1;
            upd_ok[r+1] = 1'b0; upd_err[r+1] = 1'b0; upd_ms[r+1] = 2'b00; upd_idle[r+1] = 1'b1;
            p = r;
            fim = 1'b1;
          end else begin
            exp_zera[k+2+IV] = 1'b1;  exp_db[k+2+IV] = 4'd1;
            exp_medir[k+3+IV] = 1'b1; exp_db[k+3+IV] = 4'd2;
            t = k + 3 + IV;
          end
        end else begin
          tent++;
          if (tent <= MAXT) begin
            exp_zera[k+1] = 1'b1;  exp_db[k+1] = 4'd1;
            exp_medir[k+2] = 1'b1; exp_db[k+2] = 4'd2;
            t = k + 2;
          end else begin
            p = k + 1;
            exp_pronto[p] = 1'b1; exp_db[p] = 4'd8;
            upd_err[p] = 1'b1; upd_ok[p] = 1'b0; upd_idle[p+1] = 1'b1;
            fim = 1'b1;
          end
        end
      end
    end
    at_cycle(p + 1, 1'b0);
  endtask

  initial begin
    @(negedge clock);
    chk_en = 1'b1;
    chk("reset_db_estado", db_estado, 4'd0);
    chk("reset_outputs", {medir, zera_sensor, pronto, agua_ok}, 4'd0);
    chk("reset_erro_modo", {1'b0, erro, modo_sensor}, 4'd0);
    at_cycle(3, 1'b0);

    // 1: majority of 1,0,1 in small mode
    script = '{1, 0, 1};
    run_seq(2'b01, 1'b0);
    chk("s1_medir_count", 4'(n_medir), 4'd3);
    chk("s1_agua_ok", {3'b000, agua_ok}, 4'd1);
    chk("s1_pronto_latency", 4'(last_pronto - last_k), 4'd3);

    // 2: 0,1,0 in large mode, spacing between measurements
    script = '{0, 1, 0};
    run_seq(2'b10, 1'b0);
    chk("s2_verdict", {2'b00, agua_ok, erro}, 4'd0);
    chk("s2_min_gap_ge_13", {3'b000, (min_gap >= 13)}, 4'd1);

    // 3: two timeouts recovered, then 1,1,1
    script = '{2, 2, 1, 1, 1};
    run_seq(2'b01, 1'b0);
    chk("s3_medir_count", 4'(n_medir), 4'd5);
    chk("s3_verdict", {2'b00, agua_ok, erro}, 4'b0010);

    // 4: three consecutive timeouts
    script = '{2, 2, 2};
    run_seq(2'b10, 1'b0);
    chk("s4_erro", {3'b000, erro}, 4'd1);
    chk("s4_medir_count", 4'(n_medir), 4'd3);
    chk("s4_pronto_latency", 4'(last_pronto - last_k), 4'd1);

    // 5: invalid mode, then simultaneous reading/timeout counted as readings
    run_seq(2'b11, 1'b0);
    chk("s5_erro", {3'b000, erro}, 4'd1);
    chk("s5_medir_count", 4'(n_medir), 4'd0);
    chk("s5_pronto_at_1", 4'(last_pronto - seq_start), 4'd1);
    script = '{3, 4, 3};
    run_seq(2'b01, 1'b0);
    chk("s5_both_verdict", {2'b00, agua_ok, erro}, 4'b0010);
    chk("s5_both_medir_count", 4'(n_medir), 4'd3);

    // 6: reset during the interval, then a full run
    script = '{1};
    run_seq(2'b10, 1'b1);
    chk("s6_db_after_reset", db_estado, 4'd0);
    chk("s6_outs_after_reset", {medir, zera_sensor, pronto, agua_ok}, 4'd0);
    script = '{1, 1, 0};
    run_seq(2'b01, 1'b0);
    chk("s6_rerun_medir_count", 4'(n_medir), 4'd3);
    chk("s6_rerun_agua_ok", {3'b000, agua_ok}, 4'd1);

    // randomized runs
    for (int i = 0; i < 30; i++) begin
      logic [1:0] m;
      m = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1) * 3) :
          (($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10);
      script.delete();
      run_seq(m, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
